// File: rtl/pc_seq_pkg.sv
// Shared constants for the KGP-RISC fetch/execute sequencer.
// State encoding, default PC increment and misalign trap vector.
package pc_seq_pkg;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam int          INSTR_B_DEF  = 4;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;

  function automatic logic is_misaligned(
    input logic [1:0] lo
  );
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC select for the sequencer: hold, sequential, branch or trap.
// Misalign trapping is enabled by defining PC_MISALIGN_TRAP_EN.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              INSTR_B  = INSTR_B_DEF,
  parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(TRAP_VEC_DEF)
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              retire,
  input  logic              halt_req,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc_nxt,
  output logic [ADDR_W-1:0] link_pc,
  output logic              trap_hit
);

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic hold;
  logic take_br;
  logic take_trap;
  logic take_seq;

  assign link_pc = pc + ADDR_W'(INSTR_B);

  // halt outranks both branch and trap
  assign hold      = !retire || halt_req;
  assign take_trap = !hold && br_taken && TRAP_EN
                     && is_misaligned(br_target[1:0]);
  assign take_br   = !hold && br_taken && !take_trap;
  assign take_seq  = !hold && !br_taken;

  always_comb begin
    pc_nxt   = pc;
    trap_hit = 1'b0;
    unique case (1'b1)
      hold:      pc_nxt = pc;
      take_trap: begin
        pc_nxt   = TRAP_VEC;
        trap_hit = 1'b1;
      end
      take_br:   pc_nxt = br_target;
      take_seq:  pc_nxt = link_pc;
      default:   pc_nxt = pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// KGP-RISC fetch/execute sequencer: PC register, fetch FSM, retire counter.
// Optional misalign trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                INSTR_B  = INSTR_B_DEF,
  parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(TRAP_VEC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic              instr_valid,
  input  logic              ex_done,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_pc,
  output logic              halted,
  output logic              trap,
  output logic [31:0]       retired_cnt
);

  logic [1:0]        state;
  logic              retire;
  logic              trap_hit;
  logic [ADDR_W-1:0] pc_nxt;

  assign retire    = (state == ST_EXEC) && ex_done;
  assign imem_addr = pc;

  pc_next_sel #(
    .ADDR_W   (ADDR_W),
    .INSTR_B  (INSTR_B),
    .TRAP_VEC (TRAP_VEC)
  ) u_sel (
    .pc        (pc),
    .retire    (retire),
    .halt_req  (halt_req),
    .br_taken  (br_taken),
    .br_target (br_target),
    .pc_nxt    (pc_nxt),
    .link_pc   (link_pc),
    .trap_hit  (trap_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      trap        <= 1'b0;
      retired_cnt <= '0;
    end else begin
      instr_valid <= 1'b0;
      trap        <= 1'b0;
      unique case (state)
        ST_FETCH: begin
          // stall only gates the rising of req
          if (!imem_req) begin
            if (!stall) imem_req <= 1'b1;
          end else if (imem_ack) begin
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (ex_done) begin
            retired_cnt <= retired_cnt + 32'd1;
            pc          <= pc_nxt;
            trap        <= trap_hit;
            if (halt_req) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          imem_req <= 1'b0;
          halted   <= 1'b1;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed cases plus random
// instruction streams checked against a transaction-level PC model.
module tb_pc_sequencer;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TB_TRAP = 1'b1;
`else
  localparam bit TB_TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        instr_valid;
  logic        ex_done;
  logic        br_taken;
  logic [31:0] br_target;
  logic        halt_req;
  logic [31:0] pc;
  logic [31:0] link_pc;
  logic        halted;
  logic        trap;
  logic [31:0] retired_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_halt;
  logic        m_trap;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .instr_valid (instr_valid),
    .ex_done     (ex_done),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .halt_req    (halt_req),
    .pc          (pc),
    .link_pc     (link_pc),
    .halted      (halted),
    .trap        (trap),
    .retired_cnt (retired_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input int s, input int a, input int e,
                           input bit br, input logic [31:0] tgt,
                           input bit hlt);
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    repeat (s) begin
      stall = 1'b1;
      tick();
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_addr", imem_addr, m_pc);
    end
    stall = 1'b0;
    tick();
    chk("req_rise", {31'd0, imem_req}, 32'd1);
    chk("trap_clr", {31'd0, trap}, 32'd0);
    repeat (a) begin
      stall = 1'($urandom);
      tick();
      chk("req_hold", {31'd0, imem_req}, 32'd1);
      chk("fetch_addr", imem_addr, m_pc);
    end
    stall    = 1'b0;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("req_drop", {31'd0, imem_req}, 32'd0);
    chk("ivalid", {31'd0, instr_valid}, 32'd1);
    chk("link_pc", link_pc, m_pc + 32'd4);
    repeat (e) begin
      imem_ack = 1'($urandom);
      br_taken = 1'($urandom);
      halt_req = 1'($urandom);
      tick();
      chk("ivalid_pulse", {31'd0, instr_valid}, 32'd0);
      chk("exec_req", {31'd0, imem_req}, 32'd0);
      chk("exec_pc", pc, m_pc);
    end
    imem_ack  = 1'b0;
    ex_done   = 1'b1;
    br_taken  = br;
    br_target = tgt;
    halt_req  = hlt;
    tick();
    ex_done  = 1'b0;
    br_taken = 1'b0;
    halt_req = 1'b0;
    m_ret  = m_ret + 32'd1;
    m_trap = 1'b0;
    if (hlt) begin
      m_halt = 1'b1;
    end else if (br) begin
      if (TB_TRAP && (tgt % 4 != 0)) begin
        m_pc   = 32'h0000_0100;
        m_trap = 1'b1;
      end else begin
        m_pc = tgt;
      end
    end else begin
      m_pc = m_pc + 32'd4;
    end
    chk("next_pc", pc, m_pc);
    chk("retired", retired_cnt, m_ret);
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    chk("trap", {31'd0, trap}, {31'd0, m_trap});
  endtask

  task automatic model_reset();
    m_pc   = 32'd0;
    m_ret  = 32'd0;
    m_halt = 1'b0;
    m_trap = 1'b0;
  endtask

  initial begin
    logic [31:0] t;
    reset     = 1'b1;
    stall     = 1'b0;
    imem_ack  = 1'b0;
    ex_done   = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    halt_req  = 1'b0;
    model_reset();
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_ret", retired_cnt, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_instr(0, 1, 1, 1'b0, 32'h0, 1'b0);
    run_instr(5, 0, 0, 1'b1, 32'h10, 1'b0);
    run_instr(0, 0, 2, 1'b1, 32'h40, 1'b0);
    run_instr(0, 3, 0, 1'b1, 32'h42, 1'b0);
    run_instr(1, 0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    run_instr(0, 0, 0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      run_instr($urandom_range(0, 2), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom), t, 1'b0);
    end

    stall = 1'b0;
    tick();
    chk("mid_req", {31'd0, imem_req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_req", {31'd0, imem_req}, 32'd0);
    chk("async_pc", pc, 32'd0);
    chk("async_ret", retired_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      run_instr($urandom_range(0, 2), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom), $urandom & ~32'd3,
                1'b0);
    end
    run_instr(0, 1, 1, 1'b1, 32'h80, 1'b1);

    for (int i = 0; i < 8; i++) begin
      stall    = 1'($urandom);
      imem_ack = 1'($urandom);
      ex_done  = 1'($urandom);
      br_taken = 1'($urandom);
      halt_req = 1'($urandom);
      tick();
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_pc", pc, m_pc);
      chk("halt_ret", retired_cnt, m_ret);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
